// File: rtl/ram_partition_power_ctrl_if.sv
// Control and init-write bundle between the partition power sequencer and its neighbours.
// master = reconfiguration requester side, slave = the sequencer.
interface ram_partition_power_ctrl_if #(
    parameter int unsigned INDEX         = 6,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned NUM_PARTS     = 4,
    parameter int unsigned NUM_PARTS_LOG = 2
);
    logic                     reconfigReq_i;
    logic [NUM_PARTS_LOG:0]   partsReq_i;
    logic                     drained_i;
    logic [NUM_PARTS-1:0]     partitionGated_o;
    logic                     stallAccess_o;
    logic                     initWrEn_o;
    logic [INDEX-1:0]         initAddr_o;
    logic [WIDTH-1:0]         initData_o;
    logic                     ramReady_o;
    logic                     reconfigAck_o;
    logic [NUM_PARTS_LOG:0]   activeCnt_o;

    modport master (
        output reconfigReq_i, partsReq_i, drained_i,
        input  partitionGated_o, stallAccess_o, initWrEn_o, initAddr_o, initData_o,
               ramReady_o, reconfigAck_o, activeCnt_o
    );

    modport slave (
        input  reconfigReq_i, partsReq_i, drained_i,
        output partitionGated_o, stallAccess_o, initWrEn_o, initAddr_o, initData_o,
               ramReady_o, reconfigAck_o, activeCnt_o
    );
endinterface

// File: rtl/ram_partition_power_ctrl.sv
// Power-gating and refill sequencer for a partitioned register RAM; active partitions are
// always the lowest-numbered ones, and newly woken entries are filled before use.
module ram_partition_power_ctrl #(
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned INDEX         = 6,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned NUM_PARTS     = 4,
    parameter int unsigned NUM_PARTS_LOG = 2,
    parameter int unsigned WAKE_CYCLES   = 4,
    parameter int unsigned SEQ_RESET     = 0,
    parameter int unsigned SEQ_START     = 0
) (
    input logic                      clk,
    input logic                      reset,
    ram_partition_power_ctrl_if.slave bus
);
    localparam int unsigned PD_LOG = $clog2(DEPTH / NUM_PARTS);
    localparam int unsigned CW     = NUM_PARTS_LOG + 1;
    localparam int unsigned WCW    = $clog2(WAKE_CYCLES + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(NUM_PARTS);

    typedef enum logic [2:0] {StInit, StReady, StDrain, StGate, StWake} state_e;

    state_e               state_q;
    logic [CW-1:0]        activeCnt_q, target_q, reqClamp;
    logic [INDEX-1:0]     ptr_q, initEnd;
    logic [INDEX:0]       activeSpan;
    logic [WCW-1:0]       wakeCnt_q;
    logic                 fromWake_q;
    logic [NUM_PARTS-1:0] gateMask, gated_q;
    logic                 wrEn_q, ready_q, stall_q, ack_q;
    logic [INDEX-1:0]     addr_q;
    logic [WIDTH-1:0]     data_q, initVal;

    always_comb begin
        reqClamp = bus.partsReq_i;
        if (bus.partsReq_i == '0) begin
            reqClamp = CW'(1);
        end else if (bus.partsReq_i > MaxCnt) begin
            reqClamp = MaxCnt;
        end
        // Partitions at or above the target count are gated; lower ones are powered.
        gateMask = '0;
        for (int unsigned i = 0; i < NUM_PARTS; i++) begin
            gateMask[i] = (CW'(i) >= target_q);
        end
        activeSpan = {activeCnt_q, {PD_LOG{1'b0}}};
        initEnd    = activeSpan[INDEX-1:0] - INDEX'(1);
        initVal    = (SEQ_RESET != 0) ? WIDTH'(ptr_q) + WIDTH'(SEQ_START) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StInit;
            activeCnt_q <= MaxCnt;
            target_q    <= MaxCnt;
            ptr_q       <= '0;
            wakeCnt_q   <= '0;
            fromWake_q  <= 1'b0;
            gated_q     <= '0;
            wrEn_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            stall_q     <= 1'b1;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StInit: begin
                    // Leave only once the write at initEnd has actually been presented.
                    if (wrEn_q && addr_q == initEnd) begin
                        state_q    <= StReady;
                        wrEn_q     <= 1'b0;
                        addr_q     <= '0;
                        data_q     <= '0;
                        ready_q    <= 1'b1;
                        stall_q    <= 1'b0;
                        ack_q      <= fromWake_q;
                        fromWake_q <= 1'b0;
                    end else begin
                        wrEn_q <= 1'b1;
                        addr_q <= ptr_q;
                        data_q <= initVal;
                        if (ptr_q != initEnd) ptr_q <= ptr_q + INDEX'(1);
                    end
                end
                StReady: begin
                    if (bus.reconfigReq_i) begin
                        if (reqClamp == activeCnt_q) begin
                            ack_q <= 1'b1;
                        end else begin
                            target_q <= reqClamp;
                            state_q  <= StDrain;
                            ready_q  <= 1'b0;
                            stall_q  <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (bus.drained_i) begin
                        if (target_q < activeCnt_q) begin
                            state_q <= StGate;
                        end else begin
                            state_q   <= StWake;
                            gated_q   <= gateMask;
                            wakeCnt_q <= '0;
                        end
                    end
                end
                StGate: begin
                    gated_q     <= gateMask;
                    activeCnt_q <= target_q;
                    ack_q       <= 1'b1;
                    ready_q     <= 1'b1;
                    stall_q     <= 1'b0;
                    state_q     <= StReady;
                end
                StWake: begin
                    if (wakeCnt_q == WCW'(WAKE_CYCLES - 1)) begin
                        ptr_q       <= activeSpan[INDEX-1:0];
                        activeCnt_q <= target_q;
                        fromWake_q  <= 1'b1;
                        state_q     <= StInit;
                    end else begin
                        wakeCnt_q <= wakeCnt_q + WCW'(1);
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign bus.partitionGated_o = gated_q;
    assign bus.stallAccess_o    = stall_q;
    assign bus.initWrEn_o       = wrEn_q;
    assign bus.initAddr_o       = addr_q;
    assign bus.initData_o       = data_q;
    assign bus.ramReady_o       = ready_q;
    assign bus.reconfigAck_o    = ack_q;
    assign bus.activeCnt_o      = activeCnt_q;
endmodule

// File: tb/tb_ram_partition_power_ctrl.sv
// Directed bench for ram_partition_power_ctrl: init fill, gate, wake/refill, drain hold,
// request clamping and reset abort; a second instance checks sequential fill data.
module tb_ram_partition_power_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ram_partition_power_ctrl_if bus0 ();
    ram_partition_power_ctrl_if bus1 ();

    ram_partition_power_ctrl dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    ram_partition_power_ctrl #(.SEQ_RESET(1), .SEQ_START(100)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    int nChecks = 0;
    int nFails  = 0;
    int wrCount = 0;
    int dataBad = 0;
    int ackCount = 0;
    int invBad = 0;
    int wrLog [0:1023];
    logic [31:0] data5 = '0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input int limit, output int cycles);
        cycles = 0;
        while (!bus0.ramReady_o && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic waitWrite(input int limit, output int cycles);
        cycles = 0;
        while (!bus0.initWrEn_o && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic request(input logic [2:0] parts);
        bus0.reconfigReq_i = 1'b1;
        bus0.partsReq_i    = parts;
        tick();
        bus0.reconfigReq_i = 1'b0;
    endtask

    // Write log, ack count and always-true output relations, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.initWrEn_o) begin
            if (wrCount < 1024) wrLog[wrCount] = int'(bus0.initAddr_o);
            if (bus0.initData_o != 0) dataBad++;
            wrCount++;
        end
        if (bus0.reconfigAck_o) ackCount++;
        if (bus0.stallAccess_o == bus0.ramReady_o ||
            (!bus0.initWrEn_o && bus0.initAddr_o != 0)) invBad++;
        if (bus1.initWrEn_o && bus1.initAddr_o == 6'd5) data5 = bus1.initData_o;
    end

    initial begin
        int cyc, w0, a0;
        bus0.reconfigReq_i = 1'b0;
        bus0.partsReq_i    = '0;
        bus0.drained_i     = 1'b1;
        bus1.reconfigReq_i = 1'b0;
        bus1.partsReq_i    = '0;
        bus1.drained_i     = 1'b1;

        // Reset state and the full power-up fill.
        repeat (3) tick();
        checkVal("rst_ready", bus0.ramReady_o, 0);
        checkVal("rst_stall", bus0.stallAccess_o, 1);
        checkVal("rst_wren", bus0.initWrEn_o, 0);
        checkVal("rst_gated", bus0.partitionGated_o, 0);
        checkVal("rst_active", bus0.activeCnt_o, 4);
        checkVal("rst_ack", bus0.reconfigAck_o, 0);
        reset = 1'b1;
        waitReady(200, cyc);
        checkVal("init_cycles", cyc, 65);
        checkVal("init_writes", wrCount, 64);
        checkVal("init_first", wrLog[0], 0);
        checkVal("init_last", wrLog[63], 63);
        checkVal("init_data", dataBad, 0);
        checkVal("init_noack", ackCount, 0);
        checkVal("seq_data5", data5, 105);

        // Gate down to two partitions.
        a0 = ackCount;
        request(3'd2);
        checkVal("gate_drain_stall", bus0.stallAccess_o, 1);
        tick();
        tick();
        checkVal("gate_gated", bus0.partitionGated_o, 4'b1100);
        checkVal("gate_ack", bus0.reconfigAck_o, 1);
        checkVal("gate_active", bus0.activeCnt_o, 2);
        checkVal("gate_ready", bus0.ramReady_o, 1);
        tick();
        checkVal("gate_ack_once", ackCount - a0, 1);

        // Wake back to four: settle, then refill 32..63 only.
        w0 = wrCount;
        a0 = ackCount;
        request(3'd4);
        tick();
        checkVal("wake_gated", bus0.partitionGated_o, 0);
        checkVal("wake_stall", bus0.stallAccess_o, 1);
        waitWrite(50, cyc);
        checkVal("wake_settle", cyc, 5);
        waitReady(200, cyc);
        checkVal("wake_fill_cycles", cyc, 32);
        checkVal("wake_writes", wrCount - w0, 32);
        checkVal("wake_first", wrLog[w0], 32);
        checkVal("wake_last", wrLog[w0 + 31], 63);
        checkVal("wake_ack", bus0.reconfigAck_o, 1);
        checkVal("wake_active", bus0.activeCnt_o, 4);
        tick();
        checkVal("wake_ack_once", ackCount - a0, 1);

        // Drain held off for ten cycles.
        bus0.drained_i = 1'b0;
        request(3'd2);
        repeat (10) tick();
        checkVal("drain_stall", bus0.stallAccess_o, 1);
        checkVal("drain_gated", bus0.partitionGated_o, 0);
        checkVal("drain_ready", bus0.ramReady_o, 0);
        bus0.drained_i = 1'b1;
        tick();
        tick();
        checkVal("drain_gated_after", bus0.partitionGated_o, 4'b1100);
        checkVal("drain_ack", bus0.reconfigAck_o, 1);
        tick();

        // Clamping: 0 -> 1, 7 -> 4, then a same-count request.
        request(3'd0);
        tick();
        tick();
        checkVal("clamp0_gated", bus0.partitionGated_o, 4'b1110);
        checkVal("clamp0_active", bus0.activeCnt_o, 1);
        tick();
        w0 = wrCount;
        request(3'd7);
        waitReady(300, cyc);
        checkVal("clamp7_writes", wrCount - w0, 48);
        checkVal("clamp7_first", wrLog[w0], 16);
        checkVal("clamp7_active", bus0.activeCnt_o, 4);
        checkVal("clamp7_gated", bus0.partitionGated_o, 0);
        tick();
        request(3'd4);
        checkVal("same_ack", bus0.reconfigAck_o, 1);
        checkVal("same_stall", bus0.stallAccess_o, 0);
        checkVal("same_ready", bus0.ramReady_o, 1);

        // Reset mid-WAKE, then mid-INIT.
        tick();
        request(3'd2);
        tick();
        tick();
        tick();
        request(3'd4);
        tick();
        tick();
        a0 = ackCount;
        reset = 1'b0;
        tick();
        checkVal("rwake_gated", bus0.partitionGated_o, 0);
        checkVal("rwake_active", bus0.activeCnt_o, 4);
        checkVal("rwake_wren", bus0.initWrEn_o, 0);
        reset = 1'b1;
        tick();
        checkVal("rwake_addr0", bus0.initAddr_o, 0);
        checkVal("rwake_wren1", bus0.initWrEn_o, 1);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checkVal("rinit_addr0", bus0.initAddr_o, 0);
        waitReady(200, cyc);
        checkVal("rinit_cycles", cyc, 64);
        checkVal("rinit_noack", ackCount - a0, 0);
        checkVal("seq_data5_again", data5, 105);
        checkVal("invariants", invBad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
